// File: rtl/pipe_seg_pkg.sv
// Shared encodings and defaults for the pipe_seg pipeline segment register.
// Occupancy of the skid variant is read directly from the state encoding.
package pipe_seg_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } ps_state_t;

   localparam int PS_DEF_WIDTH = 32;

   function automatic logic [1:0] ps_occupancy(input ps_state_t s);
      return logic'(s == PS_TWO) ? 2'd2 : ((s == PS_ONE) ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Generic so it can back any performance counter, not only back-pressure.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= '0;
      end else if (inc) begin
         value <= sat_inc(value);
      end
   end

endmodule

// File: rtl/pipe_seg.sv
// Valid/ready pipeline segment register with optional registered-ready skid entry,
// flush that drops every held beat, and a saturating back-pressure counter.
module pipe_seg
   import pipe_seg_pkg::*;
#(
   parameter int WIDTH = PS_DEF_WIDTH,
   parameter int SKID  = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bp_cnt
);

   logic in_fire;
   logic out_fire;
   logic bp_inc;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign bp_inc   = out_valid & ~out_ready;

   generate
      if (SKID == 0) begin : g_single
         logic             vld_p0;
         logic [WIDTH-1:0] main_p0;

         // stage 0: single entry, ready looks through to out_ready
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               vld_p0  <= 1'b0;
               main_p0 <= '0;
            end else if (flush) begin
               vld_p0  <= 1'b0;
               main_p0 <= '0;
            end else if (in_fire) begin
               vld_p0  <= 1'b1;
               main_p0 <= in_data;
            end else if (out_fire) begin
               vld_p0  <= 1'b0;
               main_p0 <= '0;
            end
         end

         assign in_ready  = ~vld_p0 | out_ready;
         assign out_valid = vld_p0;
         assign out_data  = main_p0;
         assign occupancy = {1'b0, vld_p0};
      end else begin : g_skid
         ps_state_t        state;
         ps_state_t        state_nxt;
         logic             full_p0;
         logic [WIDTH-1:0] main_p0;
         logic [WIDTH-1:0] main_nxt;
         logic [WIDTH-1:0] skid_p0;
         logic [WIDTH-1:0] skid_nxt;

         // stage 0: main + skid entries; full_p0 keeps out_ready off the in_ready path
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state   <= PS_EMPTY;
               full_p0 <= 1'b0;
               main_p0 <= '0;
               skid_p0 <= '0;
            end else begin
               state   <= state_nxt;
               full_p0 <= (state_nxt == PS_TWO);
               main_p0 <= main_nxt;
               skid_p0 <= skid_nxt;
            end
         end

         always_comb begin
            state_nxt = state;
            main_nxt  = main_p0;
            skid_nxt  = skid_p0;
            if (flush) begin
               state_nxt = PS_EMPTY;
               main_nxt  = '0;
               skid_nxt  = '0;
            end else begin
               case (state)
                  PS_EMPTY: begin
                     if (in_fire) begin
                        state_nxt = PS_ONE;
                        main_nxt  = in_data;
                     end
                  end
                  PS_ONE: begin
                     if (in_fire && out_fire) begin
                        main_nxt = in_data;
                     end else if (in_fire) begin
                        state_nxt = PS_TWO;
                        skid_nxt  = in_data;
                     end else if (out_fire) begin
                        state_nxt = PS_EMPTY;
                        main_nxt  = '0;
                     end
                  end
                  PS_TWO: begin
                     if (out_fire) begin
                        state_nxt = PS_ONE;
                        main_nxt  = skid_p0;
                        skid_nxt  = '0;
                     end
                  end
                  default: begin
                     state_nxt = PS_EMPTY;
                     main_nxt  = '0;
                     skid_nxt  = '0;
                  end
               endcase
            end
         end

         assign in_ready  = ~full_p0;
         assign out_valid = (state != PS_EMPTY);
         assign out_data  = main_p0;
         assign occupancy = ps_occupancy(state);
      end
   endgenerate

   sat_counter #(.CNT_W(CNT_W)) u_bp_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (bp_inc),
      .value  (bp_cnt)
   );

endmodule

// File: tb/tb_pipe_seg.sv
// Scoreboard bench for pipe_seg: one single-entry and one skid instance side by side,
// each checked against a FIFO-of-beats model with capacity and saturating stall count.
module tb_pipe_seg;

   localparam int W  = 32;
   localparam int CW = 3;
   localparam int BP_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          flush     [2];
   logic          in_valid  [2];
   logic          in_ready  [2];
   logic [W-1:0]  in_data   [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [W-1:0]  out_data  [2];
   logic [1:0]    occupancy [2];
   logic [CW-1:0] bp_cnt    [2];

   pipe_seg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_single (
      .clk(clk), .resetn(resetn), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .occupancy(occupancy[0]), .bp_cnt(bp_cnt[0])
   );

   pipe_seg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_skid (
      .clk(clk), .resetn(resetn), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .occupancy(occupancy[1]), .bp_cnt(bp_cnt[1])
   );

   always #5 clk = ~clk;

   // model: beats held in the segment (scoreboard) and beats waiting upstream
   logic [W-1:0] sb0 [$];
   logic [W-1:0] sb1 [$];
   logic [W-1:0] stim0 [$];
   logic [W-1:0] stim1 [$];
   int checks = 0;
   int errors = 0;
   int bp_m [2];
   bit fire_m [2];
   bit fired [2];
   bit mon_en = 1'b0;
   bit rnd = 1'b0;

   function automatic int sb_size(int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic logic [W-1:0] sb_front(int k);
      if (sb_size(k) == 0) return '0;
      return (k == 0) ? sb0[0] : sb1[0];
   endfunction

   function automatic void sb_push(int k, logic [W-1:0] d);
      if (k == 0) sb0.push_back(d);
      else        sb1.push_back(d);
   endfunction

   function automatic logic [W-1:0] sb_pop(int k);
      if (k == 0) return sb0.pop_front();
      return sb1.pop_front();
   endfunction

   function automatic void stim_push(int k, logic [W-1:0] d);
      if (k == 0) stim0.push_back(d);
      else        stim1.push_back(d);
   endfunction

   function automatic int stim_size(int k);
      return (k == 0) ? stim0.size() : stim1.size();
   endfunction

   function automatic logic [W-1:0] stim_pop(int k);
      if (k == 0) return stim0.pop_front();
      return stim1.pop_front();
   endfunction

   task automatic check(string name, int k, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (skid=%0d): got %h, expected %h", name, k, act, exp);
      end
   endtask

   // monitor: compare every cycle, pop on each downstream transfer
   always @(negedge clk) begin : monitor
      int           sz;
      bit           rdy;
      logic [W-1:0] front;
      logic [W-1:0] popped;
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            sz    = sb_size(k);
            front = sb_front(k);
            rdy   = (k == 1) ? (sz < 2) : (sz == 0 || out_ready[k]);
            check("out_valid", k, W'(out_valid[k]), W'(sz > 0));
            check("out_data", k, out_data[k], front);
            check("occupancy", k, W'(occupancy[k]), W'(sz));
            check("in_ready", k, W'(in_ready[k]), W'(rdy));
            check("bp_cnt", k, W'(bp_cnt[k]), W'(bp_m[k]));
            fire_m[k] = in_valid[k] && rdy;
            if (sz > 0 && !out_ready[k] && bp_m[k] < BP_MAX) bp_m[k]++;
            if (out_valid[k] && out_ready[k] && !flush[k]) begin
               if (sz == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL beat (skid=%0d): got unexpected %h, expected none", k, out_data[k]);
               end else begin
                  popped = sb_pop(k);
                  check("beat", k, out_data[k], popped);
               end
            end
         end
      end
   end

   // model update at the edge: flush drops everything, otherwise accept upstream beat
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         fired[k] <= mon_en && fire_m[k];
         if (mon_en) begin
            if (flush[k]) begin
               if (k == 0) sb0.delete();
               else        sb1.delete();
            end else if (fire_m[k]) begin
               sb_push(k, in_data[k]);
            end
         end
      end
   end

   // upstream driver: holds a beat until accepted, then takes the next one
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!in_valid[k] || fired[k]) begin
            if (stim_size(k) > 0) begin
               in_valid[k] = 1'b1;
               in_data[k]  = stim_pop(k);
            end else if (rnd) begin
               in_valid[k] = ($urandom_range(0, 3) != 0);
               in_data[k]  = $urandom;
            end else begin
               in_valid[k] = 1'b0;
               in_data[k]  = '0;
            end
         end
      end
   end

   task automatic set_ctrl(bit r0, bit r1, bit fl);
      out_ready[0] = r0;
      out_ready[1] = r1;
      flush[0] = fl;
      flush[1] = fl;
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // call at posedge+1: asserts reset mid-cycle and checks outputs before any clock edge
   task automatic do_reset();
      #2;
      resetn = 1'b0;
      mon_en = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_out_valid", k, W'(out_valid[k]), '0);
         check("rst_out_data", k, out_data[k], '0);
         check("rst_occupancy", k, W'(occupancy[k]), '0);
         check("rst_bp_cnt", k, W'(bp_cnt[k]), '0);
         in_valid[k] = 1'b0;
         in_data[k]  = '0;
         bp_m[k]     = 0;
         fire_m[k]   = 1'b0;
      end
      sb0.delete();
      sb1.delete();
      stim0.delete();
      stim1.delete();
      set_ctrl(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) check("rst_in_ready", k, W'(in_ready[k]), W'(1));
      mon_en = 1'b1;
   endtask

   task automatic drain(int max);
      int n;
      n = 0;
      set_ctrl(1'b1, 1'b1, 1'b0);
      while ((stim0.size() + stim1.size() + sb0.size() + sb1.size() != 0 ||
              in_valid[0] || in_valid[1]) && n < max) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL drain: got timeout after %0d cycles, expected empty", n);
      end
   endtask

   initial begin
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         in_data[k]  = '0;
         bp_m[k]     = 0;
      end
      set_ctrl(1'b0, 1'b0, 1'b0);
      cycles(2);
      do_reset();

      // back-to-back streaming
      set_ctrl(1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         stim_push(0, W'(i));
         stim_push(1, W'(i));
      end
      drain(40);

      // fill main + skid, third beat must wait upstream, then release in order
      set_ctrl(1'b0, 1'b0, 1'b0);
      foreach (stim0[i]) stim0.delete();
      stim_push(0, 32'hA); stim_push(0, 32'hB); stim_push(0, 32'hC);
      stim_push(1, 32'hA); stim_push(1, 32'hB); stim_push(1, 32'hC);
      cycles(5);
      check("skid_full_occ", 1, W'(occupancy[1]), W'(2));
      check("skid_full_ready", 1, W'(in_ready[1]), '0);
      drain(40);

      // flush while full, with upstream and downstream both offering beats
      set_ctrl(1'b0, 1'b0, 1'b0);
      stim_push(0, 32'h11); stim_push(0, 32'h12); stim_push(0, 32'h13);
      stim_push(1, 32'h11); stim_push(1, 32'h12); stim_push(1, 32'h13);
      cycles(4);
      set_ctrl(1'b1, 1'b1, 1'b1);
      cycles(1);
      for (int k = 0; k < 2; k++) begin
         check("flush_valid", k, W'(out_valid[k]), '0);
         check("flush_data", k, out_data[k], '0);
         check("flush_occ", k, W'(occupancy[k]), '0);
      end
      drain(40);

      // back-pressure saturation from a clean counter
      do_reset();
      stim_push(0, 32'h55);
      stim_push(1, 32'h55);
      cycles(12);
      for (int k = 0; k < 2; k++) check("bp_saturated", k, W'(bp_cnt[k]), W'(BP_MAX));

      // single-entry in_ready follows out_ready within the cycle
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      #1 check("comb_ready_hi", 0, W'(in_ready[0]), W'(1));
      out_ready[0] = 1'b0;
      #1 check("comb_ready_lo", 0, W'(in_ready[0]), '0);
      drain(40);

      // randomized traffic with occasional flush and one mid-stream reset
      rnd = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         out_ready[0] = ($urandom_range(0, 3) != 0);
         out_ready[1] = ($urandom_range(0, 3) != 0);
         flush[0] = ($urandom_range(0, 31) == 0);
         flush[1] = ($urandom_range(0, 31) == 0);
         if (i == 700) do_reset();
      end
      rnd = 1'b0;
      drain(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
